// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequential front-end for the 4-op M-bit ALU. The shared switch bus `value`
//   is captured as operand A, operand B and finally the opcode, each step
//   confirmed by a single-cycle `enter` pulse. `undo` steps back one state.
//   Once the opcode is confirmed, the result and flags are computed, registered
//   and held.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   value[M-1:0] : switch bus (A, B, or opcode in bits [1:0])
//   enter        : confirm pulse
//   undo         : step-back pulse (wins over enter)
//   a_reg, b_reg : captured operands
//   op_reg[1:0]  : captured opcode (00 SUB, 01 ADD, 10 OR, 11 AND)
//   result       : registered ALU result
//   flags[4:0]   : registered {N,Z,C,V,P}
//   result_valid : high while in SHOW_RESULT
//   done         : one-cycle pulse on entry to SHOW_RESULT
//   state_leds   : one-hot state {SHOW_RESULT,WAIT_OPCODE,WAIT_OP2,WAIT_OP1}
//   display      : live `value` while collecting inputs, result when showing
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [M-1:0] value,
   input  logic         enter,
   input  logic         undo,
   output logic [M-1:0] a_reg,
   output logic [M-1:0] b_reg,
   output logic [1:0]   op_reg,
   output logic [M-1:0] result,
   output logic [4:0]   flags,
   output logic         result_valid,
   output logic         done,
   output logic [3:0]   state_leds,
   output logic [M-1:0] display
);

   // One-hot encoding doubles as the LED pattern.
   typedef enum logic [3:0] {
      WAIT_OP1    = 4'b0001,
      WAIT_OP2    = 4'b0010,
      WAIT_OPCODE = 4'b0100,
      SHOW_RESULT = 4'b1000
   } state_t;

   state_t state;

   // Returns {R, N, Z, C, V, P}. Arithmetic is done in M+1 bits so bit M is
   // the carry/borrow.
   function automatic logic [M+4:0] alu(input logic [M-1:0] a,
                                        input logic [M-1:0] b,
                                        input logic [1:0]   op);
      logic [M:0]   w;
      logic [M-1:0] r;
      logic         c;
      logic         v;
      w = '0;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         2'b00: begin
            w = {1'b0, a} - {1'b0, b};
            r = w[M-1:0];
            c = w[M];
            v = (r[M-1] & ~a[M-1] & b[M-1]) | (~r[M-1] & a[M-1] & ~b[M-1]);
         end
         2'b01: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[M-1:0];
            c = w[M];
            v = (r[M-1] & ~a[M-1] & ~b[M-1]) | (~r[M-1] & a[M-1] & b[M-1]);
         end
         2'b10:   r = a | b;
         default: r = a & b;
      endcase
      return {r, r[M-1], ~|r, c, v, ^r};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= WAIT_OP1;
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= '0;
         result <= '0;
         flags  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (undo) begin
            // Stepping back never touches captured data.
            case (state)
               WAIT_OP2:    state <= WAIT_OP1;
               WAIT_OPCODE: state <= WAIT_OP2;
               SHOW_RESULT: state <= WAIT_OPCODE;
               default:     state <= WAIT_OP1;
            endcase
         end else if (enter) begin
            case (state)
               WAIT_OP1: begin
                  a_reg <= value;
                  state <= WAIT_OP2;
               end
               WAIT_OP2: begin
                  b_reg <= value;
                  state <= WAIT_OPCODE;
               end
               WAIT_OPCODE: begin
                  op_reg          <= value[1:0];
                  {result, flags} <= alu(a_reg, b_reg, value[1:0]);
                  done            <= 1'b1;
                  state           <= SHOW_RESULT;
               end
               default: state <= WAIT_OP1;   // SHOW_RESULT: start over, hold data
            endcase
         end
      end
   end

   assign state_leds   = state;
   assign result_valid = (state == SHOW_RESULT);
   assign display      = (state == SHOW_RESULT) ? result : value;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
   localparam int M = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [M-1:0] value;
   logic         enter;
   logic         undo;
   logic [M-1:0] a_reg, b_reg, result, display;
   logic [1:0]   op_reg;
   logic [4:0]   flags;
   logic         result_valid, done;
   logic [3:0]   state_leds;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: step index 0..3 = OP1, OP2, OPCODE, SHOW.
   int       m_st;
   int       m_a, m_b, m_op, m_res, m_flg;
   bit       m_done;

   alu_seq_ctrl #(.M(M)) dut (
      .clk(clk), .reset(reset), .value(value), .enter(enter), .undo(undo),
      .a_reg(a_reg), .b_reg(b_reg), .op_reg(op_reg), .result(result),
      .flags(flags), .result_valid(result_valid), .done(done),
      .state_leds(state_leds), .display(display)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags from plain integer arithmetic: carry = unsigned out of range /
   // borrow, overflow = signed result out of the M-bit signed range.
   function automatic void model_alu(input int a, input int b, input int op,
                                     output int r, output int f);
      int sa, sb, full, sfull, c, v, n, z, p;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      c = 0; v = 0; full = 0; sfull = 0;
      case (op)
         0: begin full = a - b; sfull = sa - sb; c = (a < b) ? 1 : 0; end
         1: begin full = a + b; sfull = sa + sb; c = (full > 255) ? 1 : 0; end
         2: full = a | b;
         default: full = a & b;
      endcase
      if (op < 2) v = (sfull < -128 || sfull > 127) ? 1 : 0;
      r = full & 255;
      n = (r >= 128) ? 1 : 0;
      z = (r == 0) ? 1 : 0;
      p = 0;
      for (int i = 0; i < 8; i++) p ^= (r >> i) & 1;
      f = n * 16 + z * 8 + c * 4 + v * 2 + p;
   endfunction

   function automatic void model_step(input int v, input bit e, input bit u, input bit r);
      m_done = 0;
      if (r) begin
         m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0;
      end else if (u) begin
         if (m_st > 0) m_st = m_st - 1;
      end else if (e) begin
         case (m_st)
            0: begin m_a = v; m_st = 1; end
            1: begin m_b = v; m_st = 2; end
            2: begin
               m_op = v % 4;
               model_alu(m_a, m_b, m_op, m_res, m_flg);
               m_done = 1;
               m_st = 3;
            end
            default: m_st = 0;
         endcase
      end
   endfunction

   // Drive on the falling edge, advance the model at the rising edge, then
   // compare every output 1 ns later.
   task automatic cyc(input int v, input bit e, input bit u, input bit r);
      @(negedge clk);
      value = v[M-1:0]; enter = e; undo = u; reset = r;
      @(posedge clk);
      model_step(v & 255, e, u, r);
      #1;
      chk("a_reg",        a_reg,        m_a);
      chk("b_reg",        b_reg,        m_b);
      chk("op_reg",       op_reg,       m_op);
      chk("result",       result,       m_res);
      chk("flags",        flags,        m_flg);
      chk("done",         done,         m_done);
      chk("result_valid", result_valid, (m_st == 3) ? 1 : 0);
      chk("state_leds",   state_leds,   1 << m_st);
      chk("display",      display,      (m_st == 3) ? m_res : (v & 255));
   endtask

   task automatic enter_v(input int v);
      cyc(v, 1, 0, 0);
   endtask

   task automatic idle(input int v);
      cyc(v, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; value = '0; enter = 1'b0; undo = 1'b0;
      m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0; m_done = 0;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);

      // Reset mid-sequence from WAIT_OPCODE.
      enter_v(8'h12); enter_v(8'h34);
      chk("pre_reset_leds", state_leds, 4'b0100);
      cyc(8'h01, 1, 0, 1);
      cyc(8'h01, 0, 0, 1);
      chk("rst_leds", state_leds, 4'b0001);
      chk("rst_a", a_reg, 0);
      chk("rst_b", b_reg, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_done", done, 0);

      // 5 + 3 ADD
      enter_v(8'h05); enter_v(8'h03); enter_v(8'h01);
      chk("add_res", result, 8'h08);
      chk("add_flags", flags, 5'b00001);
      chk("add_done", done, 1);
      chk("add_leds", state_leds, 4'b1000);
      idle(8'h00);
      chk("add_done_pulse", done, 0);

      // Signed overflow on ADD, borrow on SUB.
      enter_v(0);
      enter_v(8'h7F); enter_v(8'h01); enter_v(8'h01);
      chk("ovf_res", result, 8'h80);
      chk("ovf_flags", flags, 5'b10011);
      enter_v(0);
      enter_v(8'h03); enter_v(8'h05); enter_v(8'h00);
      chk("sub_res", result, 8'hFE);
      chk("sub_flags", flags, 5'b10101);
      chk("model_sub", m_flg, 5'b10101);

      // AND to zero, then OR to all ones.
      enter_v(0);
      enter_v(8'hF0); enter_v(8'h0F); enter_v(8'hFF);   // upper bits ignored -> AND
      chk("and_res", result, 8'h00);
      chk("and_flags", flags, 5'b01000);
      chk("and_op", op_reg, 2'b11);
      enter_v(0);
      enter_v(8'hF0); enter_v(8'h0F); enter_v(8'h02);
      chk("or_res", result, 8'hFF);
      chk("or_flags", flags, 5'b10000);

      // Undo walk.
      enter_v(0);
      enter_v(8'h11);
      cyc(8'h00, 0, 1, 0);
      chk("undo_leds", state_leds, 4'b0001);
      chk("undo_a_kept", a_reg, 8'h11);
      enter_v(8'h22);
      chk("recap_a", a_reg, 8'h22);
      enter_v(8'h33);
      cyc(8'h01, 1, 1, 0);
      chk("both_leds", state_leds, 4'b0010);
      chk("both_done", done, 0);
      chk("both_result", result, 8'hFF);
      enter_v(8'h33);
      enter_v(8'h01);
      chk("add2_res", result, 8'h55);
      chk("add2_flags", flags, 5'b00000);

      // SHOW_RESULT exits, display mux, recompute after undo.
      idle(8'hA5);
      chk("show_display", display, 8'h55);
      cyc(8'h00, 0, 1, 0);
      chk("undo_show_leds", state_leds, 4'b0100);
      enter_v(8'h00);
      chk("resub_res", result, 8'hEF);
      chk("resub_flags", flags, 5'b10101);
      enter_v(8'h3C);
      chk("exit_leds", state_leds, 4'b0001);
      idle(8'h5A);
      chk("op1_display", display, 8'h5A);
      chk("held_result", result, 8'hEF);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int v;
         bit e, u, r;
         v = $urandom_range(0, 255);
         e = ($urandom_range(0, 99) < 45);
         u = ($urandom_range(0, 99) < 12);
         r = ($urandom_range(0, 99) < 2);
         cyc(v, e, u, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequential front-end for the team's 4-op M-bit ALU (SUB/ADD/OR/AND, 5-bit flags).
- A single shared switch bus `value` is captured in three steps, each confirmed with `enter`: operand A, then operand B, then the opcode.
- The block then computes, registers and holds the result and flags.
- Sits between the debounced board buttons/switches and the display/LED drivers; contains its own ALU instance or an equivalent function.

Parameters:
- M, 8, operand/result width in bits (M ≥ 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  M  switch bus; sampled as A, B, or OpCode (bits [1:0]) depending on state.
- enter  input  1  single-cycle confirm pulse (already debounced/edge-detected upstream).
- undo  input  1  single-cycle pulse; step back one state.
- a_reg  output  M  captured operand A.
- b_reg  output  M  captured operand B.
- op_reg  output  2  captured opcode.
- result  output  M  registered ALU result.
- flags  output  5  registered {N,Z,C,V,P}.
- result_valid  output  1  high while in SHOW_RESULT.
- done  output  1  one-cycle pulse on entry to SHOW_RESULT.
- state_leds  output  4  one-hot state: [0]=WAIT_OP1, [1]=WAIT_OP2, [2]=WAIT_OPCODE, [3]=SHOW_RESULT.
- display  output  M  WAIT_OP1/WAIT_OP2/WAIT_OPCODE: live `value`; SHOW_RESULT: result.

Behaviour:

Reset:
- Synchronous, active-high, on `clk`; takes effect on the edge where reset=1, including mid-sequence.
- FSM goes to WAIT_OP1.
- a_reg, b_reg, op_reg, result, flags, done = 0; result_valid = 0; state_leds = 4'b0001.

FSM, evaluated each rising edge (undo has priority over enter when both are high):
- WAIT_OP1:
  - enter: a_reg <= value; go to WAIT_OP2.
  - undo: ignored.
- WAIT_OP2:
  - enter: b_reg <= value; go to WAIT_OPCODE.
  - undo: go to WAIT_OP1; a_reg is kept.
- WAIT_OPCODE:
  - enter: op_reg <= value[1:0]; result/flags <= ALU(a_reg, b_reg, value[1:0]); done <= 1 for that one cycle; go to SHOW_RESULT.
  - undo: go to WAIT_OP2.
- SHOW_RESULT:
  - enter: go to WAIT_OP1; a_reg, b_reg, op_reg, result and flags are held until overwritten.
  - undo: go to WAIT_OPCODE.

Timing:
- Result/flags visible in the cycle after the opcode-confirming enter edge, i.e. latency 1 clock.
- No capture occurs without enter.
- Registers update only on their own state's enter.

ALU function (all widths M, computed in M+1 bits):
- 00 SUB: {C,R} = A − B, where C is bit M of the (M+1)-bit difference (1 when A < B unsigned). V = (R[M-1]&~A[M-1]&B[M-1]) | (~R[M-1]&A[M-1]&~B[M-1]).
- 01 ADD: {C,R} = A + B. V = (R[M-1]&~A[M-1]&~B[M-1]) | (~R[M-1]&A[M-1]&B[M-1]).
- 10 OR and 11 AND: R = A|B or A&B; C = 0; V = 0.
- For all ops: N = R[M-1]; Z = (R == 0); P = XOR-reduce(R); flags = {N,Z,C,V,P}.

Other rules:
- enter/undo held high for multiple cycles are treated as one event per cycle; this is upstream's responsibility and the block does not filter.
- value bits [M-1:2] are ignored in WAIT_OPCODE.
- No latches; all outputs are fully defined in every state.

Test Plan:
1. reset=1 for 2 cycles mid-sequence (in WAIT_OPCODE) -> state_leds=0001, a_reg=b_reg=result=flags=0, done=0.
2. M=8; enter with value=0x05, 0x03, 0x01 (ADD) -> next cycle result=0x08, flags=00000 (P=1? no: 0x08 has one set bit -> P=1), so flags=00001; done pulses exactly 1 cycle; state_leds=1000.
3. A=0x7F, B=0x01, op 01 -> result=0x80, flags N=1,Z=0,C=0,V=1,P=1 = 10011. Then A=0x03, B=0x05, op 00 -> result=0xFE, C=1, V=0, N=1, Z=0, P=1 = 10101.
4. A=0xF0, B=0x0F, op 11 -> result=0x00, flags=01000. Then op 10 in a new sequence -> 0xFF, flags=10000 (P=0, 8 ones).
5. Undo walk: capture A=0x11; undo -> WAIT_OP1, a_reg still 0x11; enter 0x22 -> a_reg=0x22. In WAIT_OPCODE assert enter and undo in the same cycle -> goes to WAIT_OP2, no result update, no done.
6. SHOW_RESULT: enter -> WAIT_OP1 with result held; display follows value in WAIT_OP1 and shows result in SHOW_RESULT; undo from SHOW_RESULT -> WAIT_OPCODE; new op 00 recomputes with the held A and B.
